// File: rtl/fu_controller.sv
// Command sequencer for the combinational functional_unit: runs multi-step ops and returns the accumulator.
// Optional overflow/reserved-op error reporting is built when FU_CTRL_ERR_EN is defined.
module fu_controller #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] fu_a,
    output logic [WIDTH-1:0] fu_y,
    output logic [2:0]       fu_sel,
    input  logic [WIDTH-1:0] fu_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
`ifdef FU_CTRL_ERR_EN
    output logic             rsp_err,
`endif
    output logic [WIDTH-1:0] acc
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ONE  = 3'b001;
    localparam logic [2:0] OP_LOAD = 3'b010;
    localparam logic [2:0] OP_INC  = 3'b100;
    localparam logic [2:0] OP_INCN = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;

    localparam logic [2:0] SEL_ADD  = 3'b000;
    localparam logic [2:0] SEL_ONE  = 3'b001;
    localparam logic [2:0] SEL_PASS = 3'b010;
    localparam logic [2:0] SEL_NOP  = 3'b011;
    localparam logic [2:0] SEL_INC  = 3'b100;

    logic [1:0]       r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_opd;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_cnt;
    logic             r_clr;
    logic [WIDTH-1:0] r_acc;

    logic             w_accept;
    logic             w_exec;
    logic             w_last;

    assign w_accept  = (r_state == ST_IDLE) && cmd_valid;
    assign w_exec    = (r_state == ST_EXEC);
    assign cmd_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_data  = r_acc;
    assign acc       = r_acc;

    always_comb begin
        fu_sel = SEL_NOP;
        fu_a   = '0;
        fu_y   = r_acc;
        if (w_exec) begin
            case (r_op)
                OP_ADD: begin
                    fu_sel = SEL_ADD;
                    fu_a   = r_acc;
                    fu_y   = r_opd;
                end
                OP_ONE:  fu_sel = SEL_ONE;
                OP_LOAD: begin
                    fu_sel = SEL_PASS;
                    fu_y   = r_opd;
                end
                OP_INC:  fu_sel = SEL_INC;
                // INCN 0 still takes one step, passing acc through unchanged
                OP_INCN: fu_sel = (r_opd == '0) ? SEL_PASS : SEL_INC;
                OP_MUL: begin
                    if (r_clr) begin
                        fu_sel = SEL_PASS;
                        fu_y   = '0;
                    end else begin
                        fu_sel = SEL_ADD;
                        fu_a   = r_acc;
                        fu_y   = r_mcand;
                    end
                end
                default: fu_sel = SEL_NOP;
            endcase
        end
    end

    always_comb begin
        case (r_op)
            OP_INCN: w_last = (r_cnt <= WIDTH'(1));
            OP_MUL:  w_last = r_clr ? (r_cnt == '0) : (r_cnt == WIDTH'(1));
            default: w_last = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_opd   <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
            r_clr   <= 1'b0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op    <= cmd_op;
                        r_opd   <= cmd_data;
                        r_mcand <= r_acc;
                        r_cnt   <= cmd_data;
                        r_clr   <= (cmd_op == OP_MUL);
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_acc <= fu_z;
                    r_clr <= 1'b0;
                    // the MUL clear step does not consume a repeat count
                    if (!r_clr && r_cnt != '0)
                        r_cnt <= r_cnt - WIDTH'(1);
                    if (w_last)
                        r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef FU_CTRL_ERR_EN
    logic r_err;
    logic w_wrap;

    assign w_wrap  = ((fu_sel == SEL_ADD) || (fu_sel == SEL_INC)) && (fu_z < r_acc);
    assign rsp_err = r_err && rsp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err <= 1'b0;
        else if (w_accept)
            r_err <= 1'b0;
        else if (w_exec && (w_wrap || r_op == 3'b111))
            r_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_fu_controller.sv
// Directed self-checking bench for fu_controller with a behavioural functional_unit model.
// Error-reporting checks are compiled when FU_CTRL_ERR_EN is defined.
module tb_fu_controller;

    localparam int W = 10;
    localparam logic [2:0] ADD = 3'b000, ONE = 3'b001, LOAD = 3'b010, NOP = 3'b011;
    localparam logic [2:0] INC = 3'b100, INCN = 3'b101, MUL = 3'b110, RSV = 3'b111;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic [W-1:0] fu_a, fu_y, fu_z;
    logic [2:0]   fu_sel;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic [W-1:0] acc;
`ifdef FU_CTRL_ERR_EN
    logic         rsp_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0] sel_tr [16];

    always #5 clk = ~clk;

    // functional_unit reference behaviour
    always_comb begin
        case (fu_sel)
            3'b000:  fu_z = fu_a + fu_y;
            3'b001:  fu_z = W'(1);
            3'b010:  fu_z = fu_y;
            3'b011:  fu_z = fu_y;
            3'b100:  fu_z = fu_y + W'(1);
            default: fu_z = '0;
        endcase
    end

    fu_controller #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .fu_a(fu_a), .fu_y(fu_y), .fu_sel(fu_sel), .fu_z(fu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
`ifdef FU_CTRL_ERR_EN
        .rsp_err(rsp_err),
`endif
        .acc(acc)
    );

    // Issues one command and counts EXEC cycles until rsp_valid; leaves the bench in RESP.
    task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] d,
                           output int cyc, output logic [W-1:0] res, output logic err);
        int guard = 0;
        while (cmd_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 2000) begin
            if (cyc < 16) sel_tr[cyc] = fu_sel;
            cyc++;
            @(posedge clk); #1;
        end
        res = rsp_data;
`ifdef FU_CTRL_ERR_EN
        err = rsp_err;
`else
        err = 1'b0;
`endif
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; rsp_ready = 1'b1;
        #2;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (acc !== 10'd0) begin n_bad++; $display("FAIL reset_acc got %0d want 0", acc); end
        n_cmp++; if (rsp_data !== 10'd0) begin n_bad++; $display("FAIL reset_rsp_data got %0d want 0", rsp_data); end
        n_cmp++; if (fu_sel !== 3'b011) begin n_bad++; $display("FAIL reset_fu_sel got %b want 011", fu_sel); end
        n_cmp++; if (fu_a !== 10'd0) begin n_bad++; $display("FAIL reset_fu_a got %0d want 0", fu_a); end
        n_cmp++; if (fu_y !== 10'd0) begin n_bad++; $display("FAIL reset_fu_y got %0d want 0", fu_y); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_ops;
        logic [2:0]   ops  [5] = '{LOAD, ADD, INC, ONE, NOP};
        logic [W-1:0] dat  [5] = '{10'd5, 10'd7, 10'd0, 10'd0, 10'd0};
        logic [W-1:0] want [5] = '{10'd5, 10'd12, 10'd13, 10'd1, 10'd1};
        int cyc; logic [W-1:0] res; logic err;
        for (int i = 0; i < 5; i++) begin
            run_cmd(ops[i], dat[i], cyc, res, err);
            n_cmp++; if (cyc != 1) begin n_bad++; $display("FAIL single_cycles[%0d] got %0d want 1", i, cyc); end
            n_cmp++; if (res !== want[i]) begin n_bad++; $display("FAIL single_result[%0d] got %0d want %0d", i, res, want[i]); end
        end
    endtask

    task automatic test_incn;
        int cyc; logic [W-1:0] res; logic err;
        run_cmd(LOAD, 10'd3, cyc, res, err);
        run_cmd(INCN, 10'd4, cyc, res, err);
        n_cmp++; if (cyc != 4) begin n_bad++; $display("FAIL incn4_cycles got %0d want 4", cyc); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (sel_tr[i] !== 3'b100) begin n_bad++; $display("FAIL incn4_sel[%0d] got %b want 100", i, sel_tr[i]); end
        end
        n_cmp++; if (res !== 10'd7) begin n_bad++; $display("FAIL incn4_result got %0d want 7", res); end
        run_cmd(INCN, 10'd0, cyc, res, err);
        n_cmp++; if (cyc != 1) begin n_bad++; $display("FAIL incn0_cycles got %0d want 1", cyc); end
        n_cmp++; if (sel_tr[0] !== 3'b010) begin n_bad++; $display("FAIL incn0_sel got %b want 010", sel_tr[0]); end
        n_cmp++; if (res !== 10'd7) begin n_bad++; $display("FAIL incn0_result got %0d want 7", res); end
    endtask

    task automatic test_mul;
        int cyc; logic [W-1:0] res; logic err;
        run_cmd(LOAD, 10'd12, cyc, res, err);
        run_cmd(MUL, 10'd10, cyc, res, err);
        n_cmp++; if (cyc != 11) begin n_bad++; $display("FAIL mul10_cycles got %0d want 11", cyc); end
        n_cmp++; if (sel_tr[0] !== 3'b010) begin n_bad++; $display("FAIL mul10_clear_sel got %b want 010", sel_tr[0]); end
        for (int i = 1; i < 11; i++) begin
            n_cmp++; if (sel_tr[i] !== 3'b000) begin n_bad++; $display("FAIL mul10_sel[%0d] got %b want 000", i, sel_tr[i]); end
        end
        n_cmp++; if (res !== 10'd120) begin n_bad++; $display("FAIL mul10_result got %0d want 120", res); end
        run_cmd(MUL, 10'd0, cyc, res, err);
        n_cmp++; if (cyc != 1) begin n_bad++; $display("FAIL mul0_cycles got %0d want 1", cyc); end
        n_cmp++; if (res !== 10'd0) begin n_bad++; $display("FAIL mul0_result got %0d want 0", res); end
        // 100 * 20 = 2000 wraps to 976
        run_cmd(LOAD, 10'd100, cyc, res, err);
        run_cmd(MUL, 10'd20, cyc, res, err);
        n_cmp++; if (cyc != 21) begin n_bad++; $display("FAIL mul20_cycles got %0d want 21", cyc); end
        n_cmp++; if (res !== 10'd976) begin n_bad++; $display("FAIL mul20_result got %0d want 976", res); end
    endtask

    task automatic test_backpressure;
        int cyc; logic [W-1:0] res; logic err;
        run_cmd(LOAD, 10'd10, cyc, res, err);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_op = ADD; cmd_data = 10'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = LOAD; cmd_data = 10'd99;
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL hold_rsp_valid[%0d] got %b want 1", i, rsp_valid); end
            n_cmp++; if (rsp_data !== 10'd13) begin n_bad++; $display("FAIL hold_rsp_data[%0d] got %0d want 13", i, rsp_data); end
            n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL hold_cmd_ready[%0d] got %b want 0", i, cmd_ready); end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL release_cmd_ready got %b want 1", cmd_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL release_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (acc !== 10'd13) begin n_bad++; $display("FAIL release_acc got %0d want 13", acc); end
        @(posedge clk); #1;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL accept_cmd_ready got %b want 0", cmd_ready); end
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL late_rsp_valid got %b want 1", rsp_valid); end
        n_cmp++; if (acc !== 10'd99) begin n_bad++; $display("FAIL late_acc got %0d want 99", acc); end
    endtask

    task automatic test_reset_abort;
        int cyc; logic [W-1:0] res; logic err;
        int pulses = 0;
        run_cmd(LOAD, 10'd2, cyc, res, err);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = MUL; cmd_data = 10'd500;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (acc !== 10'd18) begin n_bad++; $display("FAIL mid_mul_acc got %0d want 18", acc); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (acc !== 10'd0) begin n_bad++; $display("FAIL abort_acc got %0d want 0", acc); end
        n_cmp++; if (fu_sel !== 3'b011) begin n_bad++; $display("FAIL abort_fu_sel got %b want 011", fu_sel); end
        n_cmp++; if (fu_a !== 10'd0) begin n_bad++; $display("FAIL abort_fu_a got %0d want 0", fu_a); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL abort_cmd_ready got %b want 1", cmd_ready); end
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid !== 1'b0) pulses++;
            if (i == 2) begin @(negedge clk); rst_n = 1'b1; end
            @(posedge clk); #1;
        end
        n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL abort_rsp_pulses got %0d want 0", pulses); end
        run_cmd(LOAD, 10'd9, cyc, res, err);
        n_cmp++; if (res !== 10'd9) begin n_bad++; $display("FAIL post_abort_load got %0d want 9", res); end
    endtask

`ifdef FU_CTRL_ERR_EN
    task automatic test_err;
        int cyc; logic [W-1:0] res; logic err;
        run_cmd(LOAD, 10'd1023, cyc, res, err);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_load got %b want 0", err); end
        run_cmd(INC, 10'd0, cyc, res, err);
        n_cmp++; if (res !== 10'd0) begin n_bad++; $display("FAIL err_inc_result got %0d want 0", res); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_inc_flag got %b want 1", err); end
        run_cmd(RSV, 10'd55, cyc, res, err);
        n_cmp++; if (res !== 10'd0) begin n_bad++; $display("FAIL err_rsv_result got %0d want 0", res); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_rsv_flag got %b want 1", err); end
        run_cmd(ADD, 10'd1, cyc, res, err);
        n_cmp++; if (res !== 10'd1) begin n_bad++; $display("FAIL err_add_result got %0d want 1", res); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_add_flag got %b want 0", err); end
    endtask
`else
    task automatic test_rsv_nop;
        int cyc; logic [W-1:0] res; logic err;
        run_cmd(LOAD, 10'd1023, cyc, res, err);
        run_cmd(RSV, 10'd55, cyc, res, err);
        n_cmp++; if (cyc != 1) begin n_bad++; $display("FAIL rsv_cycles got %0d want 1", cyc); end
        n_cmp++; if (res !== 10'd1023) begin n_bad++; $display("FAIL rsv_result got %0d want 1023", res); end
        run_cmd(INC, 10'd0, cyc, res, err);
        n_cmp++; if (res !== 10'd0) begin n_bad++; $display("FAIL inc_wrap_result got %0d want 0", res); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_ops();
        test_incn();
        test_mul();
        test_backpressure();
        test_reset_abort();
`ifdef FU_CTRL_ERR_EN
        test_err();
`else
        test_rsv_nop();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
